mem_arbiter_rr: RTL

- Parametrised successor of the fixed 4-core memory arbiter.
- Connects CORE_NUM cores to one single-port RAM.
- Work-conserving round robin: idle cores are skipped, with no fixed per-core time slot.
- Configurable RAM read latency, flat packed buses, async reset, and a busy/grant status output for debug and perf counters.

---
 rtl/mem_arbiter_rr_pkg.sv | 23 ++
 rtl/mem_arbiter_rr_if.sv | 55 +++++
 rtl/mem_arbiter_rr_pick.sv | 32 +++
 rtl/mem_arbiter_rr.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types and helpers for the round-robin memory arbiter.
// Holds the FSM state encoding and index-width arithmetic.
package mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// Core-side and RAM-side bus bundle of the round-robin arbiter.
// slave = arbiter side, master = cores/RAM/environment side.
interface mem_arbiter_rr_if
  import mem_arb_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CORE_NUM   = 4
);
  localparam int IDX_W = idx_width(CORE_NUM);

  logic [CORE_NUM-1:0]            request;
  logic [CORE_NUM-1:0]            wren_core;
  logic [CORE_NUM*ADDR_WIDTH-1:0] address_in;
  logic [CORE_NUM*WIDTH-1:0]      data_in;
  logic [CORE_NUM*WIDTH-1:0]      data_out;
  logic [CORE_NUM-1:0]            response;
  logic [ADDR_WIDTH-1:0]          address;
  logic [WIDTH-1:0]               data_write;
  logic                           wren;
  logic [WIDTH-1:0]               data_read;
  logic                           busy;
  logic [IDX_W-1:0]               grant_idx;

  modport slave (
    input  request,
    input  wren_core,
    input  address_in,
    input  data_in,
    input  data_read,
    output data_out,
    output response,
    output address,
    output data_write,
    output wren,
    output busy,
    output grant_idx
  );

  modport master (
    output request,
    output wren_core,
    output address_in,
    output data_in,
    output data_read,
    input  data_out,
    input  response,
    input  address,
    input  data_write,
    input  wren,
    input  busy,
    input  grant_idx
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit at or above ptr_i,
// found by a priority search over the doubled request vector.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     elig_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  logic [2*N-1:0] dbl;
  logic           found;

  assign dbl = {elig_i, elig_i};

  always_comb begin
    found = 1'b0;
    idx_o = '0;
    for (int k = 0; k < 2*N; k++) begin
      if (!found && k >= int'(ptr_i) && dbl[k]) begin
        found = 1'b1;
        idx_o = (k >= N) ? IDX_W'(k - N) : IDX_W'(k);
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Work-conserving round-robin arbiter: CORE_NUM cores onto one
// single-port RAM with a fixed read latency of MEM_LATENCY cycles.
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int CORE_NUM    = 4,
  parameter int MEM_LATENCY = 4
) (
  input logic             clk,
  input logic             reset,
  mem_arbiter_rr_if.slave bus
);

  localparam int IDX_W = idx_width(CORE_NUM);
  localparam int CNT_W = idx_width(MEM_LATENCY);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wren_q, wren_d;
  logic [WIDTH-1:0]        wdata_q, wdata_d;
  logic [IDX_W-1:0]        gidx_q, gidx_d;
  logic [CORE_NUM-1:0]     resp_q, resp_d;
  logic [CORE_NUM*WIDTH-1:0] dout_q, dout_d;

  logic [CORE_NUM-1:0]     eligible;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_vld;

  // Mask the core seeing its response pulse so it is not re-granted at once
  assign eligible = bus.request & ~resp_q;

  rr_pick #(
    .N     (CORE_NUM),
    .IDX_W (IDX_W)
  ) u_pick (
    .elig_i (eligible),
    .ptr_i  (ptr_q),
    .idx_o  (pick_idx),
    .vld_o  (pick_vld)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wren_d  = wren_q;
    wdata_d = wdata_q;
    gidx_d  = gidx_q;
    resp_d  = '0;
    dout_d  = dout_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          for (int c = 0; c < CORE_NUM; c++) begin
            if (pick_idx == IDX_W'(c)) begin
              addr_d = bus.address_in[c*ADDR_WIDTH +: ADDR_WIDTH];
              wren_d = bus.wren_core[c];
              if (bus.wren_core[c])
                wdata_d = bus.data_in[c*WIDTH +: WIDTH];
            end
          end
          gidx_d  = pick_idx;
          cnt_d   = CNT_W'(MEM_LATENCY - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          for (int c = 0; c < CORE_NUM; c++) begin
            if (gidx_q == IDX_W'(c)) begin
              resp_d[c] = 1'b1;
              if (!wren_q)
                dout_d[c*WIDTH +: WIDTH] = bus.data_read;
            end
          end
          wren_d  = 1'b0;
          ptr_d   = (gidx_q == IDX_W'(CORE_NUM - 1)) ?
                    '0 : gidx_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wren_q  <= 1'b0;
      wdata_q <= '0;
      gidx_q  <= '0;
      resp_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wren_q  <= wren_d;
      wdata_q <= wdata_d;
      gidx_q  <= gidx_d;
      resp_q  <= resp_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.address    = addr_q;
  assign bus.wren       = wren_q;
  assign bus.data_write = wdata_q;
  assign bus.grant_idx  = gidx_q;
  assign bus.response   = resp_q;
  assign bus.data_out   = dout_q;
  assign bus.busy       = (state_q == ACCESS);

endmodule
